// File: rtl/lb_reg_pkg.sv
// Register offsets, reset values and response type shared by the local-bus register block.
// Pure declarations: no logic, no latency, no flow control.
package lb_reg_pkg;

    localparam logic [3:0] REG_ID        = 4'h0;
    localparam logic [3:0] REG_SCRATCH   = 4'h1;
    localparam logic [3:0] REG_CTRL      = 4'h2;
    localparam logic [3:0] REG_PULSE     = 4'h3;
    localparam logic [3:0] REG_STATUS    = 4'h4;
    localparam logic [3:0] REG_STICKY    = 4'h5;
    localparam logic [3:0] REG_UPTIME_LO = 4'h6;
    localparam logic [3:0] REG_UPTIME_HI = 4'h7;
    localparam logic [3:0] REG_WCNT      = 4'h8;

    localparam logic [31:0] SCRATCH_RST = 32'h0000_0000;
    localparam logic [31:0] CTRL_RST    = 32'h0000_0000;
    localparam logic [31:0] PULSE_RST   = 32'h0000_0000;
    localparam logic [31:0] STICKY_RST  = 32'h0000_0000;
    localparam logic [63:0] UPTIME_RST  = 64'h0;
    localparam logic [31:0] SHADOW_RST  = 32'h0000_0000;
    localparam logic [31:0] WCNT_RST    = 32'h0000_0000;

    typedef struct packed {
        logic        vld;
        logic [31:0] dat;
    } rd_rsp_t;

    // Offset 0x0 (read-only ID), 0x8 (clears itself) and 0x9 are not counted.
    function automatic logic counts_write(input logic [3:0] off);
        return (off >= REG_SCRATCH && off <= REG_UPTIME_HI) || (off >= 4'hA);
    endfunction

endpackage

// File: rtl/lb_rd_pipe.sv
// Fixed-depth read response delay line; the MSB of each word is its valid bit.
// Latency READ_DELAY cycles, one response per cycle, no backpressure; data holds when no valid passes.
module lb_rd_pipe #(
    parameter int READ_DELAY = 3,
    parameter int WIDTH      = 33
) (
    input  logic             lb_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] req_dat,
    output logic [WIDTH-1:0] rsp_dat
);

    logic [WIDTH-1:0] stage [READ_DELAY];

    // A stage only reloads its data when a valid word arrives, so the last stage holds between reads.
    always_ff @(posedge lb_clk) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_DELAY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= req_dat[WIDTH-1] ? req_dat : {1'b0, stage[0][WIDTH-2:0]};
            for (int i = 1; i < READ_DELAY; i++) begin
                stage[i] <= stage[i-1][WIDTH-1] ? stage[i-1] : {1'b0, stage[i][WIDTH-2:0]};
            end
        end
    end

    assign rsp_dat = stage[READ_DELAY-1];

endmodule

// File: rtl/lb_reg_responder.sv
// Local-bus register block: ID, scratch, ctrl, pulse, status, sticky, uptime and write counter.
// Writes act on the strobe edge; reads return READ_DELAY cycles later, fully pipelined, no backpressure.
module lb_reg_responder
    import lb_reg_pkg::*;
#(
    parameter int          READ_DELAY = 3,
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter logic [31:0] ID_WORD    = 32'h4C425231
) (
    input  logic        lb_clk,
    input  logic        reset_n,
    input  logic [23:0] lb_addr,
    input  logic        lb_write,
    input  logic        lb_read,
    input  logic [31:0] lb_wdata,
    output logic [31:0] lb_rdata,
    output logic        lb_rvalid_out,
    output logic [31:0] ctrl_out,
    output logic [31:0] pulse_out,
    input  logic [31:0] status_in,
    input  logic [31:0] sticky_in
);

    logic        hit;
    logic [3:0]  offset;
    logic        wr_hit;
    logic        rd_hit;
    logic [31:0] scratch;
    logic [31:0] sticky;
    logic [63:0] uptime;
    logic [31:0] uptime_hi_shadow;
    logic [31:0] write_count;
    logic [31:0] sticky_clr;
    logic [31:0] rd_sel;
    rd_rsp_t     rsp_req;
    rd_rsp_t     rsp_out;

    assign hit    = (lb_addr[23:4] == BASE_ADDR[23:4]);
    assign offset = lb_addr[3:0];
    assign wr_hit = lb_write & hit;
    assign rd_hit = lb_read & hit;

    assign sticky_clr = (wr_hit && offset == REG_STICKY) ? lb_wdata : '0;

    always_ff @(posedge lb_clk) begin
        if (!reset_n) begin
            scratch          <= SCRATCH_RST;
            ctrl_out         <= CTRL_RST;
            pulse_out        <= PULSE_RST;
            sticky           <= STICKY_RST;
            uptime           <= UPTIME_RST;
            uptime_hi_shadow <= SHADOW_RST;
            write_count      <= WCNT_RST;
        end else begin
            uptime    <= uptime + 64'd1;
            pulse_out <= '0;
            // Set wins over clear when an event lands on a clearing write.
            sticky    <= (sticky & ~sticky_clr) | sticky_in;

            if (wr_hit) begin
                case (offset)
                    REG_SCRATCH: scratch   <= lb_wdata;
                    REG_CTRL:    ctrl_out  <= lb_wdata;
                    REG_PULSE:   pulse_out <= lb_wdata;
                    default:     ;
                endcase
            end

            // High word captured from the same cycle as the low word being read, so no carry tearing.
            if (rd_hit && offset == REG_UPTIME_LO) begin
                uptime_hi_shadow <= uptime[63:32];
            end

            if (wr_hit && offset == REG_WCNT) begin
                write_count <= '0;
            end else if (wr_hit && counts_write(offset) && write_count != 32'hFFFF_FFFF) begin
                write_count <= write_count + 32'd1;
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        if (hit) begin
            case (offset)
                REG_ID:        rd_sel = ID_WORD;
                REG_SCRATCH:   rd_sel = scratch;
                REG_CTRL:      rd_sel = ctrl_out;
                REG_STATUS:    rd_sel = status_in;
                REG_STICKY:    rd_sel = sticky;
                REG_UPTIME_LO: rd_sel = uptime[31:0];
                REG_UPTIME_HI: rd_sel = uptime_hi_shadow;
                REG_WCNT:      rd_sel = write_count;
                default:       rd_sel = '0;
            endcase
        end
    end

    always_comb begin
        rsp_req     = '0;
        rsp_req.vld = lb_read;
        rsp_req.dat = lb_read ? rd_sel : '0;
    end

    lb_rd_pipe #(
        .READ_DELAY (READ_DELAY),
        .WIDTH      ($bits(rd_rsp_t))
    ) u_rd_pipe (
        .lb_clk  (lb_clk),
        .reset_n (reset_n),
        .req_dat (rsp_req),
        .rsp_dat (rsp_out)
    );

    assign lb_rdata      = rsp_out.dat;
    assign lb_rvalid_out = rsp_out.vld;

endmodule

// File: tb/tb_lb_reg_responder.sv
// Scoreboard bench for lb_reg_responder: randomized and directed bus traffic against a behavioural register model.
module tb_lb_reg_responder;

    localparam int          RD   = 3;
    localparam logic [23:0] BASE = 24'hABC120;
    localparam logic [31:0] IDW  = 32'h4C425231;
    localparam logic [63:0] PRE  = 64'h0000_0001_FFFF_FFFF;

    logic        lb_clk;
    logic        reset_n;
    logic [23:0] lb_addr;
    logic        lb_write;
    logic        lb_read;
    logic [31:0] lb_wdata;
    logic [31:0] lb_rdata;
    logic        lb_rvalid_out;
    logic [31:0] ctrl_out;
    logic [31:0] pulse_out;
    logic [31:0] status_in;
    logic [31:0] sticky_in;

    lb_reg_responder #(
        .READ_DELAY (RD),
        .BASE_ADDR  (BASE),
        .ID_WORD    (IDW)
    ) dut (
        .lb_clk        (lb_clk),
        .reset_n       (reset_n),
        .lb_addr       (lb_addr),
        .lb_write      (lb_write),
        .lb_read       (lb_read),
        .lb_wdata      (lb_wdata),
        .lb_rdata      (lb_rdata),
        .lb_rvalid_out (lb_rvalid_out),
        .ctrl_out      (ctrl_out),
        .pulse_out     (pulse_out),
        .status_in     (status_in),
        .sticky_in     (sticky_in)
    );

    initial lb_clk = 1'b0;
    always #5 lb_clk = ~lb_clk;

    int cyc = 0;
    always @(posedge lb_clk) cyc++;

    // Behavioural register state
    logic [31:0] m_scratch, m_ctrl, m_sticky, m_shadow, m_wcnt;
    logic [63:0] m_uptime;
    logic [31:0] exp_ctrl = '0;
    logic [31:0] exp_pulse = '0;
    logic [31:0] last_rdata = '0;
    logic [31:0] q_dat[$];
    int          q_due[$];
    bit          in_reset = 1'b1;
    bit          started = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input bit hit, input logic [3:0] off, input logic [31:0] st);
        if (!hit) return 32'h0;
        case (off)
            4'h0:    return IDW;
            4'h1:    return m_scratch;
            4'h2:    return m_ctrl;
            4'h4:    return st;
            4'h5:    return m_sticky;
            4'h6:    return m_uptime[31:0];
            4'h7:    return m_shadow;
            4'h8:    return m_wcnt;
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle: drive at negedge, predict, advance the model past the next posedge.
    task automatic cycle(input bit rst_n, input bit rd, input bit wr, input logic [3:0] off,
                         input bit miss, input logic [31:0] wd, input logic [31:0] sk, input bit pre);
        logic [23:0] a;
        logic [31:0] st;
        logic [31:0] clr;
        logic [31:0] n_pulse;
        bit          hit;
        @(negedge lb_clk);
        hit = !miss;
        a   = {BASE[23:4], off};
        if (miss) a[23:4] = BASE[23:4] ^ 20'($urandom_range(1, 20'hFFFFF));
        st  = $urandom;
        if (pre) begin
            force dut.uptime = PRE;
            release dut.uptime;
            m_uptime = PRE;
        end
        reset_n   = rst_n;
        lb_read   = rd;
        lb_write  = wr;
        lb_addr   = a;
        lb_wdata  = wd;
        status_in = st;
        sticky_in = sk;
        if (rst_n && rd) begin
            q_dat.push_back(model_read(hit, off, st));
            q_due.push_back(cyc + RD);
        end
        n_pulse = '0;
        if (!rst_n) begin
            m_scratch = '0; m_ctrl = '0; m_sticky = '0; m_shadow = '0; m_wcnt = '0; m_uptime = '0;
        end else begin
            if (rd && hit && off == 4'h6) m_shadow = m_uptime[63:32];
            clr = (wr && hit && off == 4'h5) ? wd : 32'h0;
            m_sticky = (m_sticky & ~clr) | sk;
            if (wr && hit) begin
                if (off == 4'h1) m_scratch = wd;
                if (off == 4'h2) m_ctrl = wd;
                if (off == 4'h3) n_pulse = wd;
                if (off == 4'h8) m_wcnt = '0;
                else if (((off >= 4'h1 && off <= 4'h7) || off >= 4'hA) && m_wcnt != 32'hFFFF_FFFF)
                    m_wcnt = m_wcnt + 32'd1;
            end
            m_uptime = m_uptime + 64'd1;
        end
        @(posedge lb_clk);
        exp_ctrl  = m_ctrl;
        exp_pulse = n_pulse;
        if (!rst_n) begin
            in_reset = 1'b1;
            q_dat.delete();
            q_due.delete();
        end else begin
            in_reset = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 4'h0, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic rd_reg(input logic [3:0] off);
        cycle(1, 1, 0, off, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic wr_reg(input logic [3:0] off, input logic [31:0] wd);
        cycle(1, 0, 1, off, 0, wd, 32'h0, 0);
    endtask

    // Monitor: pops expected responses when the DUT presents them, checks hold and side outputs.
    always @(negedge lb_clk) begin
        if (started) begin
            if (in_reset) begin
                check32("rvalid_in_reset", {31'h0, lb_rvalid_out}, 32'h0);
                check32("rdata_in_reset", lb_rdata, 32'h0);
                last_rdata = '0;
            end else begin
                while (q_due.size() > 0 && q_due[0] < cyc) begin
                    checks++; errors++;
                    $display("FAIL missing_rsp at cycle %0d: got nothing, expected %h due %0d", cyc, q_dat[0], q_due[0]);
                    void'(q_dat.pop_front()); void'(q_due.pop_front());
                end
                if (lb_rvalid_out) begin
                    if (q_due.size() > 0 && q_due[0] == cyc) begin
                        check32("rdata", lb_rdata, q_dat[0]);
                        void'(q_dat.pop_front()); void'(q_due.pop_front());
                    end else begin
                        checks++; errors++;
                        $display("FAIL unexpected_rvalid at cycle %0d: got data %h, expected no response", cyc, lb_rdata);
                    end
                    last_rdata = lb_rdata;
                end else begin
                    if (q_due.size() > 0 && q_due[0] == cyc) begin
                        checks++; errors++;
                        $display("FAIL late_rsp at cycle %0d: got rvalid 0, expected %h", cyc, q_dat[0]);
                        void'(q_dat.pop_front()); void'(q_due.pop_front());
                    end
                    check32("rdata_hold", lb_rdata, last_rdata);
                end
            end
            check32("ctrl_out", ctrl_out, exp_ctrl);
            check32("pulse_out", pulse_out, exp_pulse);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; lb_read = 1'b0; lb_write = 1'b0; lb_addr = '0;
        lb_wdata = '0; status_in = '0; sticky_in = '0;
        cycle(0, 0, 0, 4'h0, 0, 32'h0, 32'h0, 0);
        started = 1'b1;
        cycle(0, 1, 1, 4'h1, 0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0);
        while (cyc < 10) idle(1);

        // ID read issued in cycle 10, response due in cycle 13 only
        rd_reg(4'h0);
        idle(4);
        for (int o = 1; o <= 8; o++) rd_reg(4'(o));

        wr_reg(4'h1, 32'hA5A5_0F0F);
        rd_reg(4'h1);
        rd_reg(4'h8);

        wr_reg(4'h3, 32'h0000_0081);
        idle(2);
        rd_reg(4'h3);

        wr_reg(4'h2, 32'h1234_5678);
        cycle(1, 1, 1, 4'h2, 0, 32'hCAFE_F00D, 32'h0, 0);
        rd_reg(4'h2);

        cycle(1, 0, 0, 4'h0, 0, 32'h0, 32'h0000_0010, 0);
        cycle(1, 0, 1, 4'h5, 0, 32'h0000_0010, 32'h0000_0010, 0);
        rd_reg(4'h5);
        wr_reg(4'h5, 32'h0000_0010);
        rd_reg(4'h5);

        cycle(1, 1, 0, 4'h6, 0, 32'h0, 32'h0, 1);
        rd_reg(4'h7);
        rd_reg(4'h6);
        rd_reg(4'h7);

        wr_reg(4'h8, 32'h0);
        wr_reg(4'h0, 32'h1);
        wr_reg(4'h9, 32'h1);
        wr_reg(4'hF, 32'h1);
        cycle(1, 0, 1, 4'h1, 1, 32'h5555_AAAA, 32'h0, 0);
        rd_reg(4'h8);
        rd_reg(4'h1);
        cycle(1, 1, 0, 4'h0, 1, 32'h0, 32'h0, 0);
        idle(RD + 1);

        for (int i = 0; i < 800; i++) begin
            cycle(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) == 0), $urandom,
                  ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0, 0);
        end
        idle(RD + 1);

        // Reads in flight when reset asserts are discarded
        rd_reg(4'h0);
        rd_reg(4'h1);
        cycle(0, 1, 1, 4'h2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        cycle(0, 0, 1, 4'h3, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        idle(RD + 3);
        for (int o = 1; o <= 8; o++) rd_reg(4'(o));
        idle(RD + 2);

        checks++;
        if (q_due.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding responses, expected 0", q_due.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
